// File: rtl/rr_mux_arbiter_if.sv
// Shared-channel bundle between N producers, the round-robin arbiter and one sink.
// The arbiter owns grant/select and the muxed output word; producers and sink drive the rest.
interface rr_mux_arbiter_if #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
);
    logic [N-1:0]     req;
    logic [N*W-1:0]   din;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] sel;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_ready;
    logic             busy;

    modport master (
        input  req,
        input  din,
        input  out_ready,
        output gnt,
        output sel,
        output out_valid,
        output out_data,
        output busy
    );

    modport slave (
        output req,
        output din,
        output out_ready,
        input  gnt,
        input  sel,
        input  out_valid,
        input  out_data,
        input  busy
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of an N:1 data mux onto one valid/ready channel.
// The grant is held until the sink accepts the word; winners rotate to lowest priority.
module rr_mux_arbiter #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux_arbiter_if.master arb
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] ptr_inc;
    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] win;
    logic [N-1:0]     win_oh;
    logic             found;
    logic             busy;
    logic             out_valid;
    logic             xfer;

    assign busy      = (state_q == GRANT);
    assign out_valid = busy & arb.req[sel_q];
    assign xfer      = out_valid & arb.out_ready;

    assign ptr_inc = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + 1'b1;

    // In GRANT a new search only matters on xfer, so it starts after the winner.
    assign base = busy ? ptr_inc : ptr_q;

    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(base) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && arb.req[idx]) begin
                found = 1'b1;
                win   = SEL_W'(idx);
            end
        end
    end

    assign win_oh = {{(N - 1){1'b0}}, 1'b1} << win;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = win_oh;
                    sel_d   = win;
                end
            end
            GRANT: begin
                if (xfer) begin
                    ptr_d = ptr_inc;
                    if (found) begin
                        gnt_d = win_oh;
                        sel_d = win;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (!arb.req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.sel       = sel_q;
    assign arb.busy      = busy;
    assign arb.out_valid = out_valid;
    assign arb.out_data  = arb.din[sel_q * W +: W];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: grant order, hold, abort, reset and regrant.
// Transferred words are scored against a queue filled as stimulus is applied.
module tb_rr_mux_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int SEL_W = 2;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]         din_v [N];
    logic [SEL_W+W-1:0]   sb [$];

    rr_mux_arbiter_if #(.N(N), .W(W), .SEL_W(SEL_W)) bif ();

    rr_mux_arbiter #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int i);
        sb.push_back({SEL_W'(i), din_v[i]});
    endtask

    // Channel monitor: invariants every cycle, scoreboard on every accepted word.
    always @(negedge clk) begin
        logic [SEL_W+W-1:0] exp_w;
        if (rst_n === 1'b1) begin
            checks++;
            assert ($onehot0(bif.gnt) && (bif.gnt[bif.sel] === bif.busy)) else begin
                errors++;
                $error("FAIL gnt_invariant observed gnt=%b sel=%0d busy=%b expected onehot0 with gnt[sel]==busy",
                       bif.gnt, bif.sel, bif.busy);
            end
            if (bif.out_valid === 1'b1 && bif.out_ready === 1'b1) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL xfer_unexpected observed sel=%0d data=%h expected no transfer",
                           bif.sel, bif.out_data);
                end
                if (sb.size() != 0) begin
                    exp_w = sb.pop_front();
                    checks++;
                    assert ({bif.sel, bif.out_data} === exp_w) else begin
                        errors++;
                        $error("FAIL xfer_word observed=%h expected=%h",
                               {bif.sel, bif.out_data}, exp_w);
                    end
                end
            end
        end
    end

    int ord [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        rst_n         = 1'b0;
        bif.req       = '0;
        bif.out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            din_v[i] = W'($urandom);
            bif.din[i*W +: W] = din_v[i];
        end

        cyc(2);
        chk("rst_gnt", 32'(bif.gnt), 32'h0);
        chk("rst_sel", 32'(bif.sel), 32'h0);
        chk("rst_busy", 32'(bif.busy), 32'h0);
        chk("rst_valid", 32'(bif.out_valid), 32'h0);
        chk("rst_data", 32'(bif.out_data), 32'(din_v[0]));
        rst_n = 1'b1;

        // Single requester: one-cycle latency, one transfer, then abort the regrant.
        bif.req       = 4'b0001;
        bif.out_ready = 1'b1;
        push(0);
        cyc(1);
        chk("t1_gnt", 32'(bif.gnt), 32'h1);
        chk("t1_valid", 32'(bif.out_valid), 32'h1);
        chk("t1_data", 32'(bif.out_data), 32'(din_v[0]));
        cyc(1);
        chk("t1_regrant", 32'(bif.gnt), 32'h1);
        bif.req = 4'b0000;
        cyc(1);
        chk("t1_idle_busy", 32'(bif.busy), 32'h0);
        chk("t1_idle_gnt", 32'(bif.gnt), 32'h0);

        // All requesting: pointer is 1 after the first transfer.
        bif.req = 4'b1111;
        for (int k = 0; k < 7; k++) push(ord[k]);
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk($sformatf("t2_gnt%0d", k), 32'(bif.gnt), 32'(1 << ord[k]));
            chk($sformatf("t2_valid%0d", k), 32'(bif.out_valid), 32'h1);
        end
        bif.req       = 4'b0000;
        bif.out_ready = 1'b0;
        cyc(1);
        chk("t2_idle", 32'(bif.busy), 32'h0);

        // Abort of requester 2 must leave the pointer at 0.
        bif.req = 4'b0100;
        cyc(1);
        chk("t4_gnt", 32'(bif.gnt), 32'h4);
        bif.req = 4'b0000;
        cyc(1);
        chk("t4_abort_busy", 32'(bif.busy), 32'h0);
        chk("t4_abort_gnt", 32'(bif.gnt), 32'h0);
        bif.req = 4'b1100;
        cyc(1);
        chk("t4_regrant2", 32'(bif.gnt), 32'h4);
        bif.out_ready = 1'b1;
        push(2);
        push(3);
        cyc(1);
        chk("t4_next3", 32'(bif.gnt), 32'h8);
        bif.req = 4'b1000;
        cyc(1);
        chk("t6_regrant3", 32'(bif.gnt), 32'h8);
        chk("t6_busy", 32'(bif.busy), 32'h1);
        bif.req = 4'b0000;
        cyc(1);
        chk("t6_idle", 32'(bif.busy), 32'h0);

        // Stall: grant and valid held while the sink is not ready.
        bif.req       = 4'b0101;
        bif.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk($sformatf("t3_hold_gnt%0d", k), 32'(bif.gnt), 32'h1);
            chk($sformatf("t3_hold_valid%0d", k), 32'(bif.out_valid), 32'h1);
        end
        bif.out_ready = 1'b1;
        push(0);
        push(2);
        cyc(1);
        chk("t3_next2", 32'(bif.gnt), 32'h4);
        bif.req = 4'b0100;
        cyc(1);
        chk("t3_regrant2", 32'(bif.gnt), 32'h4);
        bif.req = 4'b0000;
        cyc(1);
        chk("t3_idle", 32'(bif.busy), 32'h0);

        // Reset in the middle of a stalled grant.
        bif.req       = 4'b0010;
        bif.out_ready = 1'b0;
        cyc(1);
        chk("t5_gnt", 32'(bif.gnt), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(bif.gnt), 32'h0);
        chk("t5_rst_valid", 32'(bif.out_valid), 32'h0);
        chk("t5_rst_busy", 32'(bif.busy), 32'h0);
        chk("t5_rst_sel", 32'(bif.sel), 32'h0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bif.req       = 4'b1010;
        bif.out_ready = 1'b1;
        push(1);
        cyc(1);
        chk("t5_ptr0_gnt", 32'(bif.gnt), 32'h2);
        cyc(1);
        chk("t5_next3", 32'(bif.gnt), 32'h8);
        bif.req       = 4'b0000;
        bif.out_ready = 1'b0;
        cyc(1);
        chk("t5_idle", 32'(bif.busy), 32'h0);
        cyc(2);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
